// File: rtl/data_mem_wait.sv
// Word-organised data memory with a fixed wait-state counter.
// One request is accepted at a time, and each completes with a single-cycle MemReady pulse.
module data_mem_wait #(
   parameter int unsigned ADDR_BITS = 10,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Address,
   input  logic [31:0] DataFromCtrl,
   input  logic [3:0]  WriteEnable,
   input  logic        ReadEnable,
   output logic [31:0] DataToCtrl,
   output logic        MemReady,
   output logic        Busy
);

   localparam int unsigned DEPTH = 1 << ADDR_BITS;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [3:0]             we_q, we_d;
   logic                   re_q, re_d;
   logic                   ready_q, ready_d;
   logic                   busy_q, busy_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   access_c;

   logic [31:0] mem [DEPTH];

   // State and request registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         we_q    <= 4'h0;
         re_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         re_q    <= re_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state, request latching and access decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      re_d     = re_q;
      rdata_d  = rdata_q;
      ready_d  = 1'b0;
      access_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if ((WriteEnable != 4'h0) || ReadEnable) begin
               addr_d  = Address[ADDR_BITS+1:2];
               wdata_d = DataFromCtrl;
               we_d    = WriteEnable;
               re_d    = ReadEnable;
               cnt_d   = 4'(LATENCY);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               access_c = 1'b1;
               ready_d  = 1'b1;
               state_d  = S_DONE;
               // A write takes priority; the read data is left untouched
               if (re_q && (we_q == 4'h0)) begin
                  rdata_d = mem[addr_q];
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Byte-lane array write; contents survive reset, and reset suppresses an access in the same edge
   always_ff @(posedge clk) begin
      if (rst && access_c) begin
         for (int i = 0; i < 4; i++) begin
            if (we_q[i]) begin
               mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign DataToCtrl = rdata_q;
   assign MemReady   = ready_q;
   assign Busy       = busy_q;

endmodule

// File: tb/tb_data_mem_wait.sv
// Randomised bench for data_mem_wait: one LATENCY=2 instance and one LATENCY=0 instance.
// Both are checked against a word-level memory model and the request timing rules.
module tb_data_mem_wait;

   logic        clk;
   logic        rst;
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [3:0]  we    [2];
   logic        re    [2];
   logic [31:0] dout  [2];
   logic        rdy   [2];
   logic        busy  [2];

   int checks;
   int failures;

   logic [31:0] mdl [int];
   logic [31:0] exp_dout [2];
   bit          dout_known [2];

   data_mem_wait #(.ADDR_BITS(10), .LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst), .Address(addr[0]), .DataFromCtrl(wdata[0]),
      .WriteEnable(we[0]), .ReadEnable(re[0]),
      .DataToCtrl(dout[0]), .MemReady(rdy[0]), .Busy(busy[0])
   );

   data_mem_wait #(.ADDR_BITS(10), .LATENCY(0)) u_dut0 (
      .clk(clk), .rst(rst), .Address(addr[1]), .DataFromCtrl(wdata[1]),
      .WriteEnable(we[1]), .ReadEnable(re[1]),
      .DataToCtrl(dout[1]), .MemReady(rdy[1]), .Busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int key(input int d, input logic [31:0] a);
      return d * 1024 + int'(a[11:2]);
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic idle_inputs(input int d);
      we[d] = 4'h0;
      re[d] = 1'b0;
   endtask

   // One complete request with cycle-exact checks of Busy, MemReady and DataToCtrl
   task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] w, input logic r, input bit chg);
      int lat = lat_of(d);
      int k;
      @(negedge clk);
      addr[d] = a; wdata[d] = wd; we[d] = w; re[d] = r;
      @(posedge clk); #1;
      chk("accept_busy", 32'(busy[d]), 32'd1);
      chk("accept_rdy", 32'(rdy[d]), 32'd0);
      if (chg) begin
         @(negedge clk);
         addr[d] = $urandom; wdata[d] = $urandom; we[d] = 4'(($urandom % 15) + 1);
      end
      for (int i = 0; i < lat; i++) begin
         @(posedge clk); #1;
         chk("wait_rdy", 32'(rdy[d]), 32'd0);
         chk("wait_busy", 32'(busy[d]), 32'd1);
      end
      @(posedge clk); #1;
      chk("done_rdy", 32'(rdy[d]), 32'd1);
      chk("done_busy", 32'(busy[d]), 32'd1);
      k = key(d, a);
      if (w != 4'h0) begin
         logic [31:0] cur;
         cur = mdl.exists(k) ? mdl[k] : 32'h0;
         for (int i = 0; i < 4; i++)
            if (w[i]) cur[8*i +: 8] = wd[8*i +: 8];
         // Only track words whose every byte is known
         if (mdl.exists(k) || (w == 4'hF)) mdl[k] = cur;
      end else if (r) begin
         if (mdl.exists(k)) begin
            exp_dout[d] = mdl[k];
            dout_known[d] = 1'b1;
         end else begin
            dout_known[d] = 1'b0;
         end
      end
      if (dout_known[d]) chk("dout", dout[d], exp_dout[d]);
      @(negedge clk);
      idle_inputs(d);
      @(posedge clk); #1;
      chk("after_rdy", 32'(rdy[d]), 32'd0);
      chk("after_busy", 32'(busy[d]), 32'd0);
   endtask

   initial begin
      int first, prev, cyc, pulses;
      logic [31:0] a;
      logic [3:0]  w;
      logic        r;
      checks = 0;
      failures = 0;
      for (int d = 0; d < 2; d++) begin
         addr[d] = 32'h0; wdata[d] = 32'h0; we[d] = 4'h0; re[d] = 1'b1;
         exp_dout[d] = 32'h0; dout_known[d] = 1'b1;
      end

      // Reset held with a read pending
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_rdy", 32'(rdy[d]), 32'd0);
         chk("rst_busy", 32'(busy[d]), 32'd0);
         chk("rst_dout", dout[d], 32'h0);
      end
      @(negedge clk);
      idle_inputs(0); idle_inputs(1);
      rst = 1'b1;

      for (int d = 0; d < 2; d++) begin
         txn(d, 32'h40, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
         txn(d, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0);
         chk("full_word", dout[d], 32'hDEADBEEF);
         txn(d, 32'h80, 32'h11223344, 4'hF, 1'b0, 1'b0);
         txn(d, 32'h80, 32'hAAAAAAAA, 4'h4, 1'b0, 1'b0);
         txn(d, 32'h80, 32'h0, 4'h0, 1'b1, 1'b0);
         chk("byte_lane", dout[d], 32'h11AA3344);
         txn(d, 32'h1000, 32'h5, 4'hF, 1'b0, 1'b0);
         txn(d, 32'h0000, 32'h0, 4'h0, 1'b1, 1'b0);
         chk("wrap", dout[d], 32'h5);
         txn(d, 32'h10, 32'h77, 4'hF, 1'b1, 1'b1);
         chk("rw_keeps_dout", dout[d], 32'h5);
         txn(d, 32'h10, 32'h0, 4'h0, 1'b1, 1'b1);
         chk("rw_wrote", dout[d], 32'h77);
      end

      // Reset sampled at t0+1 of a write drops the write entirely
      @(negedge clk);
      addr[0] = 32'h40; wdata[0] = 32'h12345678; we[0] = 4'hF;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      idle_inputs(0);
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_rdy", 32'(rdy[0]), 32'd0);
      chk("midrst_busy", 32'(busy[0]), 32'd0);
      chk("midrst_dout", dout[0], 32'h0);
      exp_dout[0] = 32'h0; exp_dout[1] = 32'h0;
      @(negedge clk);
      rst = 1'b1;
      txn(0, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0);
      chk("midrst_old", dout[0], 32'hDEADBEEF);

      // Held read on the zero-latency instance completes every 3 cycles
      @(negedge clk);
      addr[1] = 32'h80; re[1] = 1'b1;
      cyc = 0; pulses = 0; first = -1; prev = -1;
      while (pulses < 4 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (rdy[1]) begin
            if (prev < 0) chk("b2b_first", 32'(cyc), 32'd2);
            else chk("b2b_gap", 32'(cyc - prev), 32'd3);
            prev = cyc;
            pulses++;
         end
      end
      chk("b2b_pulses", 32'(pulses), 32'd4);
      chk("b2b_dout", dout[1], 32'h11AA3344);
      @(negedge clk);
      idle_inputs(1);
      repeat (2) @(posedge clk);

      // Random traffic over a small word set, with random upper/low address bits
      for (int n = 0; n < 120; n++) begin
         int d = n % 2;
         a = {$urandom_range(0, 7) << 12} | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         w = 4'($urandom);
         r = 1'($urandom);
         if (w == 4'h0) r = 1'b1;
         txn(d, a, $urandom, w, r, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
